riscv_dp_loadunit: RTL

//   Sequential load unit between the execute/memory stage and the data memory port.

---
 rtl/riscv_dp_loadunit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/riscv_dp_loadunit.sv
// Sequential RV32/RV64 load unit: width decode, sign/zero extension, and splitting of
// word-crossing misaligned loads into two aligned dmem accesses.
module riscv_dp_loadunit #(
   parameter int unsigned MP_DATA_WIDTH  = 32,
   parameter int unsigned MP_ADDR_WIDTH  = 32,
   parameter bit          MP_MISALIGN_EN = 1'b1
) (
   input  logic                     iclk,
   input  logic                     irst_n,
   input  logic                     ivalid,
   input  logic [MP_ADDR_WIDTH-1:0] iaddr,
   input  logic [2:0]               ifunct3,
   output logic                     oready,
   output logic                     odmem_req,
   output logic [MP_ADDR_WIDTH-1:0] odmem_addr,
   input  logic                     idmem_ack,
   input  logic [MP_DATA_WIDTH-1:0] idmem_rdata,
   output logic                     ovalid,
   output logic [MP_DATA_WIDTH-1:0] ordata,
   output logic                     ofault
);

   localparam int unsigned DW = MP_DATA_WIDTH;
   localparam int unsigned AW = MP_ADDR_WIDTH;
   localparam int unsigned NB = DW / 8;
   localparam int unsigned OW = $clog2(NB);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ0,
      S_REQ1,
      S_RESP,
      S_FAULT
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [OW-1:0] off_q, off_d;
   logic [2:0]    funct3_q, funct3_d;
   logic          cross_q, cross_d;
   logic [DW-1:0] word0_q, word0_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          fault_q, fault_d;

   logic          in_legal;
   logic          in_cross;
   logic [4:0]    in_end;

   // Shift the word pair down to the load offset, then extend from the load's top bit.
   function automatic logic [DW-1:0] extend(input logic [2*DW-1:0] pair,
                                            input logic [OW-1:0]   off,
                                            input logic [2:0]      f3);
      logic [2*DW-1:0] sh;
      logic [DW-1:0]   res;
      int unsigned     nbits;
      logic            sgn;
      sh    = pair >> {off, 3'b000};
      nbits = 32'd8 << f3[1:0];
      sgn   = ~f3[2] & sh[nbits-1];
      res   = '0;
      for (int unsigned i = 0; i < DW; i++) begin
         res[i] = (i < nbits) ? sh[i] : sgn;
      end
      return res;
   endfunction

   always_comb begin
      in_legal = 1'b0;
      case (ifunct3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: in_legal = 1'b1;
         3'b011, 3'b110:                         in_legal = (DW == 64);
         default:                                in_legal = 1'b0;
      endcase
      in_end   = 5'(iaddr[OW-1:0]) + (5'd1 << ifunct3[1:0]);
      in_cross = (in_end > 5'(NB));
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      off_d     = off_q;
      funct3_d  = funct3_q;
      cross_d   = cross_q;
      word0_d   = word0_q;
      rdata_d   = rdata_q;
      fault_d   = fault_q;
      oready    = 1'b0;
      odmem_req = 1'b0;
      ovalid    = 1'b0;

      case (state_q)
         S_IDLE: begin
            oready = 1'b1;
            if (ivalid) begin
               off_d    = iaddr[OW-1:0];
               funct3_d = ifunct3;
               cross_d  = in_cross;
               if (!in_legal || (in_cross && !MP_MISALIGN_EN)) begin
                  state_d = S_FAULT;
                  rdata_d = '0;
                  fault_d = 1'b1;
               end else begin
                  state_d = S_REQ0;
                  addr_d  = {iaddr[AW-1:OW], {OW{1'b0}}};
               end
            end
         end
         S_REQ0: begin
            odmem_req = 1'b1;
            if (idmem_ack) begin
               word0_d = idmem_rdata;
               if (cross_q) begin
                  state_d = S_REQ1;
                  addr_d  = addr_q + AW'(NB);
               end else begin
                  state_d = S_RESP;
                  rdata_d = extend({{DW{1'b0}}, idmem_rdata}, off_q, funct3_q);
                  fault_d = 1'b0;
               end
            end
         end
         S_REQ1: begin
            odmem_req = 1'b1;
            if (idmem_ack) begin
               state_d = S_RESP;
               rdata_d = extend({idmem_rdata, word0_q}, off_q, funct3_q);
               fault_d = 1'b0;
            end
         end
         S_RESP: begin
            ovalid  = 1'b1;
            state_d = S_IDLE;
         end
         S_FAULT: begin
            ovalid  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         off_q    <= '0;
         funct3_q <= '0;
         cross_q  <= 1'b0;
         word0_q  <= '0;
         rdata_q  <= '0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         off_q    <= off_d;
         funct3_q <= funct3_d;
         cross_q  <= cross_d;
         word0_q  <= word0_d;
         rdata_q  <= rdata_d;
         fault_q  <= fault_d;
      end
   end

   assign odmem_addr = addr_q;
   assign ordata     = rdata_q;
   assign ofault     = fault_q;

endmodule
